saturn_bus_prog_reader: RTL

- Consumer end of the bus-program queue that the control unit fills.
- Each queue entry is 5 bits: bit4=1 is a bus command, bit3:0 is the command code or a data nibble. The block drains entries in order and serialises them onto the Saturn nibble bus (data, strobe, cmd line), one nibble per 4-phase cycle.
- When the queue is empty and the bus is in PC-read mode, it issues read strobes and returns fetched nibbles to the control unit and decoder.
- It owns o_bus_busy, which stalls the control unit.

---
 rtl/saturn_bus_prog_reader_pkg.sv | 26 ++
 rtl/saturn_bus_prog_reader_addr_tracker.sv | 74 +++++++
 rtl/saturn_bus_prog_reader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/saturn_bus_prog_reader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// saturn_bus_prog_reader_pkg : bus command codes, controller states, defaults
// Rev 1.0
// ---------------------------------------------------------------------------
package saturn_bus_prog_reader_pkg;

  localparam logic [3:0] BUSCMD_PC_READ  = 4'h0;
  localparam logic [3:0] BUSCMD_DP_WRITE = 4'h1;
  localparam logic [3:0] BUSCMD_LOAD_PC  = 4'h4;
  localparam logic [3:0] BUSCMD_LOAD_DP  = 4'h5;

  localparam int DEF_ADDR_NIBBLES = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } bus_state_e;

  function automatic logic is_addr_load(input logic [3:0] code);
    return (code == BUSCMD_LOAD_PC) || (code == BUSCMD_LOAD_DP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/saturn_bus_prog_reader_addr_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// saturn_bus_prog_reader_addr_tracker : follows LOAD_PC/LOAD_DP address
// nibbles, derives PC-read mode and flags commands that cut an address short.
// Rev 1.0
// ---------------------------------------------------------------------------
module saturn_bus_prog_reader_addr_tracker
  import saturn_bus_prog_reader_pkg::*;
#(
  parameter int ADDR_NIBBLES = DEF_ADDR_NIBBLES,
  parameter int CNT_W        = 3
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clk_en,
  input  logic       i_latch,
  input  logic [4:0] i_entry,
  output logic       o_pc_mode,
  output logic       o_error
);

  logic [CNT_W-1:0] addr_cnt_q, addr_cnt_d;
  logic             pc_pending_q, pc_pending_d;
  logic             pc_mode_q, pc_mode_d;
  logic             error_q, error_d;

  always_comb begin
    addr_cnt_d   = addr_cnt_q;
    pc_pending_d = pc_pending_q;
    pc_mode_d    = pc_mode_q;
    error_d      = error_q;
    if (i_latch) begin
      if (i_entry[4]) begin
        if (addr_cnt_q != '0) error_d = 1'b1;
        if (is_addr_load(i_entry[3:0])) begin
          addr_cnt_d   = CNT_W'(ADDR_NIBBLES);
          pc_pending_d = (i_entry[3:0] == BUSCMD_LOAD_PC);
          // A new PC address invalidates any read stream from the old PC;
          // LOAD_DP leaves the PC untouched, so PC-read mode survives it.
          if (i_entry[3:0] == BUSCMD_LOAD_PC) pc_mode_d = 1'b0;
        end else begin
          addr_cnt_d   = '0;
          pc_pending_d = 1'b0;
          pc_mode_d    = 1'b0;
        end
      end else if (addr_cnt_q != '0) begin
        addr_cnt_d = addr_cnt_q - CNT_W'(1);
        if ((addr_cnt_q == CNT_W'(1)) && pc_pending_q) begin
          pc_mode_d    = 1'b1;
          pc_pending_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_cnt_q   <= '0;
      pc_pending_q <= 1'b0;
      pc_mode_q    <= 1'b0;
      error_q      <= 1'b0;
    end else if (i_clk_en) begin
      addr_cnt_q   <= addr_cnt_d;
      pc_pending_q <= pc_pending_d;
      pc_mode_q    <= pc_mode_d;
      error_q      <= error_d;
    end
  end

  assign o_pc_mode = pc_mode_q;
  assign o_error   = error_q;

endmodule
`default_nettype wire

// File: rtl/saturn_bus_prog_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// saturn_bus_prog_reader : drains the bus-program queue onto the Saturn nibble
// bus, one nibble per 4-phase cycle, and issues PC reads when idle.
// Rev 1.0
// ---------------------------------------------------------------------------
module saturn_bus_prog_reader
  import saturn_bus_prog_reader_pkg::*;
#(
  parameter int PTR_W        = 5,
  parameter int ADDR_NIBBLES = DEF_ADDR_NIBBLES
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clk_en,
  input  logic [3:0]       i_phases,
  input  logic [4:0]       i_program_data,
  input  logic [PTR_W-1:0] i_program_address,
  output logic [PTR_W-1:0] o_program_address,
  input  logic             i_no_read,
  output logic [3:0]       o_bus_data,
  output logic             o_bus_cmd,
  output logic             o_bus_strobe,
  output logic             o_bus_drive,
  input  logic [3:0]       i_bus_data,
  output logic [3:0]       o_nibble,
  output logic             o_nibble_valid,
  output logic             o_bus_busy,
  output logic             o_error
);

  localparam int CNT_W = $clog2(ADDR_NIBBLES + 1);

  bus_state_e       state_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [3:0]       bus_data_q;
  logic             bus_cmd_q;
  logic             bus_strobe_q;
  logic             bus_drive_q;
  logic [3:0]       nibble_q;
  logic             nibble_valid_q;
  logic             bus_busy_q;

  logic             empty;
  logic             latch_entry;
  logic             pc_mode;

  assign empty       = (rd_ptr_q == i_program_address);
  assign latch_entry = i_phases[0] && !empty;

  saturn_bus_prog_reader_addr_tracker #(
    .ADDR_NIBBLES (ADDR_NIBBLES),
    .CNT_W        (CNT_W)
  ) u_addr_tracker (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clk_en  (i_clk_en),
    .i_latch   (latch_entry),
    .i_entry   (i_program_data),
    .o_pc_mode (pc_mode),
    .o_error   (o_error)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= ST_IDLE;
      rd_ptr_q       <= '0;
      bus_data_q     <= 4'h0;
      bus_cmd_q      <= 1'b0;
      bus_strobe_q   <= 1'b0;
      bus_drive_q    <= 1'b0;
      nibble_q       <= 4'h0;
      nibble_valid_q <= 1'b0;
      bus_busy_q     <= 1'b0;
    end else if (i_clk_en) begin
      nibble_valid_q <= 1'b0;
      bus_busy_q     <= !empty || (state_q != ST_IDLE);

      if (i_phases[0]) begin
        if (!empty) begin
          bus_cmd_q   <= i_program_data[4];
          bus_data_q  <= i_program_data[3:0];
          bus_drive_q <= 1'b1;
          rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
          state_q     <= ST_WRITE;
        end else if (pc_mode && !i_no_read) begin
          bus_drive_q <= 1'b0;
          bus_cmd_q   <= 1'b0;
          state_q     <= ST_READ;
        end else begin
          state_q     <= ST_IDLE;
        end
      end

      if (i_phases[1] && (state_q != ST_IDLE)) bus_strobe_q <= 1'b1;

      if (i_phases[2]) begin
        bus_strobe_q <= 1'b0;
        if (state_q == ST_READ) begin
          nibble_q       <= i_bus_data;
          nibble_valid_q <= 1'b1;
        end
      end

      if (i_phases[3]) begin
        state_q     <= ST_IDLE;
        bus_drive_q <= 1'b0;
      end
    end
  end

  assign o_program_address = rd_ptr_q;
  assign o_bus_data        = bus_data_q;
  assign o_bus_cmd         = bus_cmd_q;
  assign o_bus_strobe      = bus_strobe_q;
  assign o_bus_drive       = bus_drive_q;
  assign o_nibble          = nibble_q;
  assign o_nibble_valid    = nibble_valid_q;
  assign o_bus_busy        = bus_busy_q;

endmodule
`default_nettype wire
